child_resp_collector: RTL and testbench

Fan-in collector sitting at the root of a generated module tree: it gathers response beats from up to 15 child instances over per-child valid/ready channels and merges them into one registered output stream tagged with the child index. A sweep FSM tracks which children have responded since the last `sweep_start`, so the root can tell when every child has reported.

---
 rtl/child_collect_pkg.sv | 6 +
 rtl/rr_arbiter.sv | 23 ++
 rtl/child_resp_collector.sv | 98 +++++++++
 tb/tb_child_resp_collector.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/child_collect_pkg.sv
// child_collect_pkg: shared types and defaults for the child response collector.
package child_collect_pkg;
    localparam int NUM_CHILD_DEF = 15;
    typedef enum logic [1:0] {IDLE, COLLECT, DONE} sweep_state_e;
    typedef logic [$clog2(NUM_CHILD_DEF)-1:0] child_idx_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, searching req upward from ptr with wrap.
module rr_arbiter #(
    parameter int NUM_CHILD = 15,
    parameter int IDX_W = $clog2(NUM_CHILD)
) (
    input  logic [NUM_CHILD-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [NUM_CHILD-1:0] grant
);
    logic [IDX_W:0]   s;
    logic [IDX_W-1:0] k;
    // Walk offsets from farthest to nearest so the closest requester after ptr wins.
    always_comb begin
        grant = '0;
        s = '0;
        k = '0;
        for (int i = NUM_CHILD - 1; i >= 0; i--) begin
            s = {1'b0, ptr} + (IDX_W+1)'(i);
            k = (s >= (IDX_W+1)'(NUM_CHILD)) ? IDX_W'(s - (IDX_W+1)'(NUM_CHILD)) : IDX_W'(s);
            if (req[k]) grant = NUM_CHILD'(1) << k;
        end
    end
endmodule

// File: rtl/child_resp_collector.sv
// child_resp_collector: round-robin fan-in of child response beats into one registered
// stream, with a sweep FSM reporting when every child has responded.
module child_resp_collector
    import child_collect_pkg::*;
#(
    parameter int NUM_CHILD = NUM_CHILD_DEF,
    parameter int DATA_W = 32,
    parameter int IDX_W = $clog2(NUM_CHILD)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CHILD-1:0]        child_valid,
    input  logic [NUM_CHILD*DATA_W-1:0] child_data,
    output logic [NUM_CHILD-1:0]        child_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic [IDX_W-1:0]            out_idx,
    input  logic                        sweep_start,
    output logic                        sweep_done,
    output logic [15:0]                 beat_cnt
);
    logic [NUM_CHILD-1:0] grant, accept_oh, seen_q, seen_d;
    logic [IDX_W-1:0]     rr_q, rr_d, gidx, out_idx_q, out_idx_d;
    logic [DATA_W-1:0]    gdata, out_data_q, out_data_d;
    logic [15:0]          cnt_q, cnt_d, cnt_base;
    logic                 out_valid_q, out_valid_d, load_en, accept;
    sweep_state_e         state_q, state_d;

    rr_arbiter #(.NUM_CHILD(NUM_CHILD), .IDX_W(IDX_W)) u_arb (
        .req   (child_valid),
        .ptr   (rr_q),
        .grant (grant)
    );

    assign load_en = !out_valid_q || out_ready;
    // rst_n gates ready so no child sees an accept while the collector is held in reset.
    assign child_ready = grant & {NUM_CHILD{load_en & rst_n}};
    assign accept_oh = child_valid & child_ready;
    assign accept = |accept_oh;

    always_comb begin
        gidx = '0;
        gdata = '0;
        for (int i = 0; i < NUM_CHILD; i++)
            if (grant[i]) begin
                gidx = IDX_W'(i);
                gdata = child_data[i*DATA_W +: DATA_W];
            end
    end

    always_comb begin
        out_valid_d = accept ? 1'b1 : out_valid_q & !out_ready;
        out_data_d = accept ? gdata : out_data_q;
        out_idx_d = accept ? gidx : out_idx_q;
        rr_d = !accept ? rr_q : (gidx == IDX_W'(NUM_CHILD - 1)) ? '0 : gidx + IDX_W'(1);
        cnt_base = sweep_start ? '0 : cnt_q;
        cnt_d = (accept && cnt_base != 16'hFFFF) ? cnt_base + 16'd1 : cnt_base;
        seen_d = (sweep_start || state_q == COLLECT) ? ((sweep_start ? '0 : seen_q) | accept_oh) : seen_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q <= '0;
            out_idx_q <= '0;
            rr_q <= '0;
            cnt_q <= '0;
            seen_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q <= out_data_d;
            out_idx_q <= out_idx_d;
            rr_q <= rr_d;
            cnt_q <= cnt_d;
            seen_q <= seen_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = sweep_start ? COLLECT
                : (state_q == COLLECT && &(seen_q | accept_oh)) ? DONE : state_q;
    end

    always_comb begin
        sweep_done = (state_q == DONE);
    end

    assign out_valid = out_valid_q;
    assign out_data = out_data_q;
    assign out_idx = out_idx_q;
    assign beat_cnt = cnt_q;
endmodule

// File: tb/tb_child_resp_collector.sv
// tb_child_resp_collector: directed bench for the fan-in collector and its sweep FSM.
module tb_child_resp_collector;
    import child_collect_pkg::*;
    localparam int N = 15;
    localparam int DW = 32;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  child_valid = '0;
    logic [N-1:0]  child_ready;
    logic [N*DW-1:0] child_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_idx;
    logic          sweep_start = 1'b0;
    logic          sweep_done;
    logic [15:0]   beat_cnt;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] dat(input int i);
        return (i == 3) ? 32'hA5A5_0003 : 32'hD000_0000 + DW'(i);
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_data
        assign child_data[g*DW +: DW] = dat(g);
    end

    child_resp_collector #(.NUM_CHILD(N), .DATA_W(DW), .IDX_W(IW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .child_valid (child_valid),
        .child_data  (child_data),
        .child_ready (child_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_idx     (out_idx),
        .sweep_start (sweep_start),
        .sweep_done  (sweep_done),
        .beat_cnt    (beat_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        child_valid = '1;
        repeat (2) tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_child_ready", child_ready, 0);
        chk("rst_sweep_done", sweep_done, 0);
        chk("rst_beat_cnt", beat_cnt, 0);
        #3 rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            chk("rr_valid", out_valid, 1);
            chk("rr_idx", out_idx, k % N);
            chk("rr_data", out_data, dat(k % N));
        end
        chk("rr_beat_cnt", beat_cnt, 16);
        chk("rr_sweep_done", sweep_done, 0);

        child_valid = 15'h0208;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("alt_idx", out_idx, (k % 2) ? 9 : 3);
            chk("alt_data", out_data, (k % 2) ? dat(9) : 32'hA5A5_0003);
        end

        out_ready = 1'b0;
        #1 chk("stall_ready0", child_ready, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("stall_valid", out_valid, 1);
            chk("stall_idx", out_idx, 9);
            chk("stall_data", out_data, dat(9));
            chk("stall_ready", child_ready, 0);
        end
        out_ready = 1'b1;
        #1 chk("unstall_ready", child_ready, 15'h0008);
        tick();
        chk("unstall_idx", out_idx, 3);
        chk("unstall_cnt", beat_cnt, 21);
        child_valid = '0;
        tick();
        chk("drain_valid", out_valid, 0);

        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        chk("sweep_cnt_clr", beat_cnt, 0);
        chk("sweep_not_done", sweep_done, 0);
        for (int c = N - 1; c >= 0; c--) begin
            child_valid = N'(1) << c;
            tick();
            chk("sweep_idx", out_idx, c);
            chk("sweep_done_edge", sweep_done, c == 0);
        end
        child_valid = '0;
        chk("sweep_cnt", beat_cnt, 15);
        tick();
        chk("sweep_done_hold", sweep_done, 1);

        child_valid = N'(1) << 5;
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        child_valid = '0;
        chk("restart_done", sweep_done, 0);
        chk("restart_cnt", beat_cnt, 1);
        chk("restart_seen", dut.seen_q, 15'h0020);
        chk("restart_state", dut.state_q, COLLECT);
        chk("restart_idx", out_idx, 5);
        tick();
        chk("restart_drain", out_valid, 0);

        out_ready = 1'b0;
        child_valid = N'(1) << 7;
        tick();
        child_valid = '0;
        chk("mid_valid", out_valid, 1);
        chk("mid_idx", out_idx, 7);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", out_valid, 0);
        chk("async_cnt", beat_cnt, 0);
        chk("async_state", dut.state_q, IDLE);
        #3 rst_n = 1'b1;
        tick();
        chk("post_state", dut.state_q, IDLE);
        chk("post_valid", out_valid, 0);
        chk("post_done", sweep_done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
